// File: rtl/simd_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction memory, register-file ports,
// ALU opcode/result and run control.
interface simd_sequencer_if #(
  parameter int OPCODE_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int IMEM_AW      = 8
);
  logic                    start;
  logic [IMEM_AW-1:0]      imem_addr;
  logic [15:0]             imem_rdata;
  logic [3:0]              rf_raddr_a;
  logic [3:0]              rf_raddr_b;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic                    rf_we;
  logic [3:0]              rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, imem_rdata, alu_out,
    output imem_addr, rf_raddr_a, rf_raddr_b, opcode,
           rf_we, rf_waddr, rf_wdata, busy, done
  );

  modport slave (
    output start, imem_rdata, alu_out,
    input  imem_addr, rf_raddr_a, rf_raddr_b, opcode,
           rf_we, rf_waddr, rf_wdata, busy, done
  );
endinterface

// File: rtl/simd_sequencer.sv
// Three-cycle FETCH/ISSUE/WB instruction sequencer driving an external ALU
// and register file, with a DOTP accumulator flushed by STORE_RESULT.
module simd_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int IMEM_AW      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  simd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DOTP  = 4'd4;
  localparam logic [3:0] OP_STRES = 4'd7;
  localparam logic [3:0] OP_STOP  = 4'd8;

  state_t                r_state;
  logic [IMEM_AW-1:0]    r_pc;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [7:0]            r_instr_hi;

  function automatic logic [3:0] legal_op(input logic [3:0] op);
    return (op > OP_STOP) ? OP_NOOP : op;
  endfunction

  logic       w_issue;
  logic       w_wb;
  logic [3:0] w_iss_op;
  logic [3:0] w_wb_op;
  logic       w_stop;
  logic       w_alu_wr;
  logic       w_res_wr;

  assign w_issue  = (r_state == S_ISSUE);
  assign w_wb     = (r_state == S_WB);
  assign w_iss_op = legal_op(bus.imem_rdata[15:12]);
  assign w_wb_op  = legal_op(r_instr_hi[7:4]);
  assign w_stop   = w_issue && (w_iss_op == OP_STOP);
  assign w_alu_wr = w_wb && ((w_wb_op == OP_ADD) || (w_wb_op == OP_SUB) ||
                             (w_wb_op == OP_MUL));
  assign w_res_wr = w_wb && (w_wb_op == OP_STRES);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_acc      <= '0;
      r_instr_hi <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pc    <= '0;
            r_acc   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_ISSUE;
        S_ISSUE: begin
          r_instr_hi <= bus.imem_rdata[15:8];
          r_state    <= w_stop ? S_HALT : S_WB;
        end
        S_WB: begin
          r_pc <= r_pc + 1'b1;
          if (w_wb_op == OP_DOTP)  r_acc <= r_acc + bus.alu_out;
          if (w_wb_op == OP_STRES) r_acc <= '0;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by rstn so a reset landing in WB never reaches the RF.
  assign bus.imem_addr  = (rstn && (r_state == S_FETCH)) ? r_pc : '0;
  assign bus.opcode     = (rstn && w_issue) ? OPCODE_WIDTH'(w_iss_op) : '0;
  assign bus.rf_raddr_a = (rstn && w_issue) ? bus.imem_rdata[7:4] : 4'd0;
  assign bus.rf_raddr_b = (rstn && w_issue) ? bus.imem_rdata[3:0] : 4'd0;
  assign bus.rf_we      = rstn && (w_alu_wr || w_res_wr);
  assign bus.rf_waddr   = bus.rf_we ? r_instr_hi[3:0] : 4'd0;
  assign bus.rf_wdata   = !rstn    ? '0 :
                          w_alu_wr ? bus.alu_out :
                          w_res_wr ? r_acc : '0;
  assign bus.busy       = rstn && ((r_state == S_FETCH) || w_issue || w_wb);
  assign bus.done       = rstn && w_stop;

endmodule

// File: tb/tb_simd_sequencer.sv
// Directed bench for simd_sequencer: instruction memory and scripted ALU
// results per instruction address, table of programs plus corner sequences.
`timescale 1ns/1ps
module tb_simd_sequencer;

  logic clk;
  logic rstn;

  simd_sequencer_if #(.OPCODE_WIDTH(4), .DATA_WIDTH(32), .IMEM_AW(8)) bus();

  simd_sequencer #(.OPCODE_WIDTH(4), .DATA_WIDTH(32), .IMEM_AW(8)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem    [256];
  logic [31:0] alu_tab [256];
  logic [15:0] r_rdata;
  logic [7:0]  r_faddr;
  logic [31:0] r_alu;

  // Instruction word one cycle after its address; ALU result one cycle later.
  always @(posedge clk) begin
    r_rdata <= imem[bus.imem_addr];
    r_faddr <= bus.imem_addr;
    r_alu   <= alu_tab[r_faddr];
  end
  assign bus.imem_rdata = r_rdata;
  assign bus.alu_out    = r_alu;

  typedef struct packed {
    logic [5:0][15:0] prog;
    logic [5:0][31:0] alu;
    int               nw;
    logic [3:0]       wa0;
    logic [31:0]      wd0;
    int               wc0;
    logic [3:0]       wa1;
    logic [31:0]      wd1;
    int               wc1;
    int               done_c;
    logic [3:0]       op0;
    int               restart;
  } vec_t;

  vec_t vecs [8];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '0;
    for (int i = 0; i < 6; i++) v.prog[i] = 16'h8000;
    v.restart = -1;
    return v;
  endfunction

  task automatic check_idle(input string name);
    check(name, {bus.opcode, bus.imem_addr, bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_we,
                 bus.rf_waddr, bus.rf_wdata, bus.busy, bus.done}, 64'd0);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) begin
      imem[i]    = 16'h8000;
      alu_tab[i] = 32'd0;
    end
    for (int i = 0; i < 6; i++) begin
      imem[i]    = v.prog[i];
      alu_tab[i] = v.alu[i];
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          nw;
    int          dc;
    int          viol;
    logic [3:0]  op0;
    logic [3:0]  wa [4];
    logic [31:0] wd [4];
    int          wc [4];
    nw = 0; dc = -1; viol = 0; op0 = 4'hx;
    for (int i = 0; i < 4; i++) begin wa[i] = 0; wd[i] = 0; wc[i] = -1; end
    load(v);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.start = (c == v.restart);
      if (c == 2) op0 = bus.opcode;
      if (bus.rf_we) begin
        if (nw < 4) begin wa[nw] = bus.rf_waddr; wd[nw] = bus.rf_wdata; wc[nw] = c; end
        nw++;
      end else if (bus.rf_waddr != 0 || bus.rf_wdata != 0) begin
        viol++;
      end
      if (bus.done) begin dc = c; break; end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_busy_after", idx), {bus.busy, bus.done}, 64'd0);
    check($sformatf("v%0d_nwrites", idx), nw, v.nw);
    check($sformatf("v%0d_done_cycle", idx), dc, v.done_c);
    check($sformatf("v%0d_op0", idx), op0, v.op0);
    check($sformatf("v%0d_idle_zero", idx), viol, 0);
    if (v.nw > 0)
      check($sformatf("v%0d_w0", idx), {wa[0], wd[0], wc[0][7:0]}, {v.wa0, v.wd0, v.wc0[7:0]});
    if (v.nw > 1)
      check($sformatf("v%0d_w1", idx), {wa[1], wd[1], wc[1][7:0]}, {v.wa1, v.wd1, v.wc1[7:0]});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_lo;
    int we_cnt;
    n_vec = 0;
    n_err = 0;

    // ADD d1 then STOP
    vecs[0] = blank();
    vecs[0].prog[0] = 16'h1123; vecs[0].alu[0] = 32'd7;
    vecs[0].nw = 1; vecs[0].wa0 = 4'd1; vecs[0].wd0 = 32'd7; vecs[0].wc0 = 3;
    vecs[0].done_c = 5; vecs[0].op0 = 4'd1;
    // DOTP x3, STORE_RESULT d5, STORE_RESULT d6 (acc already flushed)
    vecs[1] = blank();
    vecs[1].prog[0] = 16'h4000; vecs[1].prog[1] = 16'h4000; vecs[1].prog[2] = 16'h4000;
    vecs[1].prog[3] = 16'h7500; vecs[1].prog[4] = 16'h7600;
    vecs[1].alu[0] = 32'd2; vecs[1].alu[1] = 32'd3; vecs[1].alu[2] = 32'd4;
    vecs[1].alu[3] = 32'h77; vecs[1].alu[4] = 32'h88;
    vecs[1].nw = 2; vecs[1].wa0 = 4'd5; vecs[1].wd0 = 32'd9; vecs[1].wc0 = 12;
    vecs[1].wa1 = 4'd6; vecs[1].wd1 = 32'd0; vecs[1].wc1 = 15;
    vecs[1].done_c = 17; vecs[1].op0 = 4'd4;
    // Opcode 0xC executes as NOOP, then SUB d2
    vecs[2] = blank();
    vecs[2].prog[0] = 16'hC123; vecs[2].prog[1] = 16'h2234;
    vecs[2].alu[0] = 32'h11; vecs[2].alu[1] = 32'd5;
    vecs[2].nw = 1; vecs[2].wa0 = 4'd2; vecs[2].wd0 = 32'd5; vecs[2].wc0 = 6;
    vecs[2].done_c = 8; vecs[2].op0 = 4'd0;
    // MUL d15, STORE_TEMP_S1, STORE_TEMP_S2, NOOP
    vecs[3] = blank();
    vecs[3].prog[0] = 16'h3F00; vecs[3].prog[1] = 16'h5000; vecs[3].prog[2] = 16'h6000;
    vecs[3].prog[3] = 16'h0000;
    vecs[3].alu[0] = 32'hFFFF_FFFF; vecs[3].alu[1] = 32'h55; vecs[3].alu[2] = 32'h66;
    vecs[3].alu[3] = 32'h99;
    vecs[3].nw = 1; vecs[3].wa0 = 4'd15; vecs[3].wd0 = 32'hFFFF_FFFF; vecs[3].wc0 = 3;
    vecs[3].done_c = 14; vecs[3].op0 = 4'd3;
    // Accumulator wraps modulo 2^32
    vecs[4] = blank();
    vecs[4].prog[0] = 16'h4000; vecs[4].prog[1] = 16'h4000; vecs[4].prog[2] = 16'h7000;
    vecs[4].alu[0] = 32'hFFFF_FFFF; vecs[4].alu[1] = 32'd2; vecs[4].alu[2] = 32'h5A;
    vecs[4].nw = 1; vecs[4].wa0 = 4'd0; vecs[4].wd0 = 32'd1; vecs[4].wc0 = 9;
    vecs[4].done_c = 11; vecs[4].op0 = 4'd4;
    // Immediate STOP
    vecs[5] = blank();
    vecs[5].nw = 0; vecs[5].done_c = 2; vecs[5].op0 = 4'd8;
    // start re-pulsed while busy
    vecs[6] = blank();
    vecs[6].prog[0] = 16'h1123; vecs[6].prog[1] = 16'h2234;
    vecs[6].alu[0] = 32'd7; vecs[6].alu[1] = 32'd5;
    vecs[6].nw = 2; vecs[6].wa0 = 4'd1; vecs[6].wd0 = 32'd7; vecs[6].wc0 = 3;
    vecs[6].wa1 = 4'd2; vecs[6].wd1 = 32'd5; vecs[6].wc1 = 6;
    vecs[6].done_c = 8; vecs[6].op0 = 4'd1; vecs[6].restart = 4;
    // Opcode 0xF between DOTP and STORE_RESULT leaves acc alone
    vecs[7] = blank();
    vecs[7].prog[0] = 16'h4000; vecs[7].prog[1] = 16'hF123; vecs[7].prog[2] = 16'h7300;
    vecs[7].alu[0] = 32'd6; vecs[7].alu[1] = 32'd99; vecs[7].alu[2] = 32'h42;
    vecs[7].nw = 1; vecs[7].wa0 = 4'd3; vecs[7].wd0 = 32'd6; vecs[7].wc0 = 9;
    vecs[7].done_c = 11; vecs[7].op0 = 4'd4;

    rstn = 1'b0;
    bus.start = 1'b0;
    load(vecs[0]);
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    rstn = 1'b1;
    @(negedge clk);
    check_idle("idle_after_reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset landing in the WB cycle of ADD
    load(vecs[0]);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    check("rst_wb_we", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_wb_after", {bus.busy, bus.opcode, bus.done}, 64'd0);
    we_cnt = 0; busy_lo = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rf_we) we_cnt++;
      if (bus.busy) busy_lo++;
    end
    check("rst_wb_quiet", {we_cnt[15:0], busy_lo[15:0]}, 64'd0);

    // 256+ NOOPs, pc wraps without halting
    for (int i = 0; i < 256; i++) begin imem[i] = 16'h0000; alu_tab[i] = 32'd1; end
    @(negedge clk); bus.start = 1'b1;
    busy_lo = 0; we_cnt = 0;
    for (int c = 1; c <= 3 * 257 + 1; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.busy) busy_lo++;
      if (bus.rf_we || bus.done) we_cnt++;
      if (c == 3 * 255 + 1) check("wrap_addr_255", bus.imem_addr, 8'd255);
      if (c == 3 * 256 + 1) check("wrap_addr_0", {bus.busy, bus.imem_addr}, {1'b1, 8'd0});
      if (c == 3 * 257 + 1) check("wrap_addr_1", bus.imem_addr, 8'd1);
    end
    check("wrap_busy_held", busy_lo, 0);
    check("wrap_no_write", we_cnt, 0);
    rstn = 1'b0;
    @(negedge clk);
    check_idle("final_reset");
    rstn = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
